pc_ctrl: RTL

Sequencing controller for the program counter. Each cycle it takes the decoded control op for the instruction at `prog_ctr`, the branch condition and stall status, and drives the counter's `reset`, `reljump_en`, `absjump_en` and `target` inputs. It adds three things the counter lacks:
- a hold (encoded as a relative jump of 0);
- a HALT/resume state;
- a 4-entry return-address stack (RAS) for CALL/RET.

It sits between the decoder and the program counter.

---
 rtl/pc_ctrl_if.sv | 31 +++
 rtl/pc_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pc_ctrl_if.sv
// Control bundle between decoder/counter and pc_ctrl: decoded op and status in,
// counter controls and stack status out.
interface pc_ctrl_if #(
  parameter int D = 12
);
  logic [D-1:0] prog_ctr;
  logic         instr_valid;
  logic [2:0]   op;
  logic         cond_ok;
  logic [D-1:0] offset;
  logic [D-1:0] abs_addr;
  logic         stall;
  logic         resume;
  logic         pc_reset;
  logic         reljump_en;
  logic         absjump_en;
  logic [D-1:0] target;
  logic         halted;
  logic         ras_overflow;
  logic         ras_underflow;

  modport master (
    output prog_ctr, instr_valid, op, cond_ok, offset, abs_addr, stall, resume,
    input  pc_reset, reljump_en, absjump_en, target, halted, ras_overflow, ras_underflow
  );

  modport slave (
    input  prog_ctr, instr_valid, op, cond_ok, offset, abs_addr, stall, resume,
    output pc_reset, reljump_en, absjump_en, target, halted, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter sequencer: INIT/RUN/HALT FSM driving the counter's jump/reset
// controls, with a circular return-address stack for CALL/RET.
module pc_ctrl #(
  parameter int D         = 12,
  parameter int RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_ctrl_if.slave bus
);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0] RAS_FULL = (PW+1)'(RAS_DEPTH);

  localparam logic [2:0] OP_BR   = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HALT} state_t;

  typedef struct packed {
    logic         pc_reset;
    logic         rel;
    logic         abs;
    logic [D-1:0] tgt;
  } ctl_t;

  state_t state, state_nx;
  ctl_t   ctl;

  logic [RAS_DEPTH-1:0][D-1:0] ras_mem;
  logic [PW-1:0]               wptr;
  logic [PW-1:0]               top;
  logic [PW:0]                 cnt;
  logic [D-1:0]                link;
  logic                        push, pop, set_unf;
  logic                        ras_full, ras_empty;
  logic                        ovf_q, unf_q;

  assign ras_full  = (cnt == RAS_FULL);
  assign ras_empty = (cnt == '0);
  assign top       = wptr - 1'b1;
  assign link      = bus.prog_ctr + D'(1);

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    pop      = 1'b0;
    set_unf  = 1'b0;
    ctl      = '0;
    case (state)
      ST_INIT: begin
        ctl.pc_reset = 1'b1;
        state_nx     = ST_RUN;
      end
      ST_RUN: begin
        if (bus.stall) begin
          ctl.rel = 1'b1;
        end else if (bus.instr_valid) begin
          case (bus.op)
            OP_BR: begin
              if (bus.cond_ok) begin
                ctl.rel = 1'b1;
                ctl.tgt = bus.offset;
              end
            end
            OP_JMP: begin
              ctl.abs = 1'b1;
              ctl.tgt = bus.abs_addr;
            end
            OP_CALL: begin
              push    = 1'b1;
              ctl.abs = 1'b1;
              ctl.tgt = bus.abs_addr;
            end
            OP_RET: begin
              // An empty-stack return lands on address 0 rather than garbage.
              ctl.abs = 1'b1;
              if (ras_empty) begin
                set_unf = 1'b1;
              end else begin
                pop     = 1'b1;
                ctl.tgt = ras_mem[top];
              end
            end
            OP_HALT: begin
              ctl.rel  = 1'b1;
              state_nx = ST_HALT;
            end
            default: ;
          endcase
        end
      end
      ST_HALT: begin
        if (bus.resume) state_nx = ST_RUN;
        else            ctl.rel  = 1'b1;
      end
      default: begin
        ctl.pc_reset = 1'b1;
        state_nx     = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_INIT;
    else        state <= state_nx;
  end

  // Full stack keeps count at depth; the write pointer simply overwrites the oldest slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
        if (ras_full) ovf_q <= 1'b1;
        else          cnt   <= cnt + 1'b1;
      end else if (pop) begin
        wptr <= top;
        cnt  <= cnt - 1'b1;
      end
      if (set_unf) unf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_mem[wptr] <= link;
  end

  assign bus.pc_reset      = ctl.pc_reset;
  assign bus.reljump_en    = ctl.rel;
  assign bus.absjump_en    = ctl.abs;
  assign bus.target        = ctl.tgt;
  assign bus.halted        = (state == ST_HALT);
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
endmodule
